// File: rtl/alu_wide.sv
// Wide ALU sequencer: splits W-bit operations into WORD-bit lanes run through an external ALU.
// Optional macro ALU_WIDE_OVF_EN enables signed-overflow reporting on rsp_ovf for ADD/SUB.
package alu_wide_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NAND = 4'd5,
    ALU_NOR  = 4'd6,
    ALU_XNOR = 4'd7,
    ALU_MUL  = 4'd8,
    ALU_SHL  = 4'd9,
    ALU_SHR  = 4'd10,
    ALU_PASS = 4'd11
  } e_alu_op;
endpackage

// state | meaning
// IDLE  | ready for a request
// RUN   | one lane per cycle through the external ALU, LSB lane first
// DONE  | response held until rsp_ready
module alu_wide
  import alu_wide_pkg::*;
#(
  parameter int WORD  = 8,
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  e_alu_op               req_op,
  input  logic [WORD*LANES-1:0] req_a,
  input  logic [WORD*LANES-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WORD*LANES-1:0] rsp_result,
  output logic                  rsp_cout,
  output logic                  rsp_zero,
  output logic                  rsp_err,
  output logic                  rsp_ovf,
  output e_alu_op               alu_op,
  output logic [WORD-1:0]       alu_srcA,
  output logic [WORD-1:0]       alu_srcB,
  output logic                  alu_cin,
  output logic                  alu_sign,
  input  logic [WORD-1:0]       alu_result,
  input  logic                  alu_cout
);

  localparam int W  = WORD * LANES;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  e_alu_op         op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [LW-1:0]   lane;
  logic            carry_q;

  logic            req_supported;
  logic            is_sub;
  logic            is_arith;
  logic            last_lane;
  logic [WORD-1:0] lane_a;
  logic [WORD-1:0] lane_b;

  always_comb begin
    req_supported = req_op inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
                                   ALU_XOR, ALU_NAND, ALU_NOR, ALU_XNOR};
    is_sub    = (op_q == ALU_SUB);
    is_arith  = (op_q == ALU_ADD) || is_sub;
    last_lane = (lane == LW'(LANES - 1));
    lane_a    = a_q[lane*WORD +: WORD];
    lane_b    = b_q[lane*WORD +: WORD];
  end

  // SUB is run as A + ~B + 1 on the external adder
  always_comb begin
    alu_op   = ALU_ADD;
    alu_srcA = '0;
    alu_srcB = '0;
    alu_cin  = 1'b0;
    alu_sign = 1'b0;
    if (state == RUN) begin
      alu_srcA = lane_a;
      alu_srcB = is_sub ? ~lane_b : lane_b;
      if (is_arith) begin
        alu_cin = (lane == '0) ? is_sub : carry_q;
      end else begin
        alu_op = op_q;
      end
    end
  end

  assign rsp_zero = rsp_valid && (rsp_result == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_ovf    <= 1'b0;
      lane       <= '0;
      carry_q    <= 1'b0;
      op_q       <= ALU_ADD;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q       <= req_op;
            a_q        <= req_a;
            b_q        <= req_b;
            lane       <= '0;
            carry_q    <= 1'b0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
            rsp_ovf    <= 1'b0;
            req_ready  <= 1'b0;
            if (req_supported) begin
              rsp_err <= 1'b0;
              state   <= RUN;
            end else begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        RUN: begin
          rsp_result[lane*WORD +: WORD] <= alu_result;
          carry_q <= alu_cout;
          if (last_lane) begin
            rsp_cout  <= is_arith && alu_cout;
`ifdef ALU_WIDE_OVF_EN
            rsp_ovf   <= is_arith && (alu_srcA[WORD-1] == alu_srcB[WORD-1])
                         && (alu_result[WORD-1] != alu_srcA[WORD-1]);
`endif
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else begin
            lane <= lane + LW'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wide.sv
// Self-checking bench for alu_wide: directed cases plus random requests against a 32-bit arithmetic model.
// Define ALU_WIDE_OVF_EN for both RTL and bench to check the overflow feature.
module tb_alu_wide;
  import alu_wide_pkg::*;

  localparam int WORD  = 8;
  localparam int LANES = 4;
  localparam int W     = WORD * LANES;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  e_alu_op         req_op;
  logic [W-1:0]    req_a, req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [W-1:0]    rsp_result;
  logic            rsp_cout, rsp_zero, rsp_err, rsp_ovf;
  e_alu_op         alu_op;
  logic [WORD-1:0] alu_srcA, alu_srcB, alu_result;
  logic            alu_cin, alu_sign, alu_cout;
  logic [WORD:0]   alu_sum;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_wide #(.WORD(WORD), .LANES(LANES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_ovf(rsp_ovf),
    .alu_op(alu_op), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
    .alu_cin(alu_cin), .alu_sign(alu_sign),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  // Combinational 8-bit lane ALU the block drives
  always_comb begin
    alu_sum    = '0;
    alu_result = '0;
    alu_cout   = 1'b0;
    case (alu_op)
      ALU_ADD:  begin alu_sum = {1'b0, alu_srcA} + {1'b0, alu_srcB} + {{WORD{1'b0}}, alu_cin};
                      alu_result = alu_sum[WORD-1:0]; alu_cout = alu_sum[WORD]; end
      ALU_AND:  alu_result = alu_srcA & alu_srcB;
      ALU_OR:   alu_result = alu_srcA | alu_srcB;
      ALU_XOR:  alu_result = alu_srcA ^ alu_srcB;
      ALU_NAND: alu_result = ~(alu_srcA & alu_srcB);
      ALU_NOR:  alu_result = ~(alu_srcA | alu_srcB);
      ALU_XNOR: alu_result = ~(alu_srcA ^ alu_srcB);
      default:  alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: whole-word arithmetic on the 32-bit operands
  task automatic model(input e_alu_op op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic cout, output logic err,
                       output logic ovf, output int lat);
    logic [W:0] s;
    res = '0; cout = 0; err = 0; ovf = 0; lat = LANES + 1;
    case (op)
      ALU_ADD:  begin s = {1'b0, a} + {1'b0, b}; res = s[W-1:0]; cout = s[W]; end
      ALU_SUB:  begin res = a - b; cout = (a >= b); end
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_NAND: res = ~(a & b);
      ALU_NOR:  res = ~(a | b);
      ALU_XNOR: res = ~(a ^ b);
      default:  begin err = 1; lat = 1; end
    endcase
`ifdef ALU_WIDE_OVF_EN
    if (op == ALU_ADD) ovf = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
    if (op == ALU_SUB) ovf = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
`endif
  endtask

  task automatic check_rsp(input string tag, input logic [W-1:0] res, input logic cout,
                           input logic err, input logic ovf);
    check({tag, ".result"}, rsp_result, res);
    check({tag, ".cout"},   rsp_cout, cout);
    check({tag, ".zero"},   rsp_zero, res == '0);
    check({tag, ".err"},    rsp_err, err);
    check({tag, ".ovf"},    rsp_ovf, ovf);
    check({tag, ".valid"},  rsp_valid, 1'b1);
    check({tag, ".ready"},  req_ready, 1'b0);
    check({tag, ".sign"},   alu_sign, 1'b0);
  endtask

  task automatic run_req(input string tag, input e_alu_op op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int hold);
    logic [W-1:0] e_res;
    logic e_cout, e_err, e_ovf;
    int e_lat, lat;
    model(op, a, b, e_res, e_cout, e_err, e_ovf, e_lat);
    @(negedge clk);
    check({tag, ".idle_ready"}, req_ready, 1'b1);
    req_valid = 1; req_op = op; req_a = a; req_b = b; rsp_ready = 0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, lat, e_lat);
    check_rsp(tag, e_res, e_cout, e_err, e_ovf);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1;
      req_op = e_alu_op'($urandom_range(0, 11));
      req_a = $urandom; req_b = $urandom;
      @(negedge clk);
      check_rsp({tag, ".hold"}, e_res, e_cout, e_err, e_ovf);
    end
    req_valid = 1; req_op = ALU_ADD;
    rsp_ready = 1;
    @(negedge clk);
    check({tag, ".release_valid"}, rsp_valid, 1'b0);
    check({tag, ".release_ready"}, req_ready, 1'b1);
    req_valid = 0; rsp_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1; req_valid = 0; req_op = ALU_ADD; req_a = '0; req_b = '0; rsp_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.req_ready", req_ready, 1'b1);
    check("rst.rsp_valid", rsp_valid, 1'b0);
    check("rst.result", rsp_result, '0);
    check("rst.cout", rsp_cout, 1'b0);
    check("rst.zero", rsp_zero, 1'b0);
    check("rst.err", rsp_err, 1'b0);
    check("rst.ovf", rsp_ovf, 1'b0);
    check("rst.alu_op", alu_op, ALU_ADD);
    check("rst.alu_src", {alu_srcA, alu_srcB, alu_cin, alu_sign}, '0);
    rst = 0;

    run_req("add_carry", ALU_ADD, 32'h00FF_FFFF, 32'h0000_0001, 0);
    run_req("sub_borrow", ALU_SUB, 32'h0000_0000, 32'h0000_0001, 0);
    run_req("sub_small", ALU_SUB, 32'd5, 32'd3, 1);
    run_req("xor_zero", ALU_XOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0);
    run_req("mul_err", ALU_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    run_req("hold3", ALU_NAND, 32'hF0F0_1234, 32'h0FF0_FFFF, 3);
    run_req("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    run_req("sub_ovf", ALU_SUB, 32'h8000_0000, 32'h0000_0001, 0);

    // Reset in the middle of lane 2
    @(negedge clk);
    req_valid = 1; req_op = ALU_ADD; req_a = 32'hFFFF_FFFF; req_b = 32'h1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midrst.valid", rsp_valid, 1'b0);
    check("midrst.ready", req_ready, 1'b1);
    check("midrst.result", rsp_result, '0);
    @(negedge clk);
    check("midrst.still_idle", rsp_valid, 1'b0);
    run_req("post_rst_add", ALU_ADD, 32'd1, 32'd1, 0);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 3))
        0: ra = '1;
        1: rb = ra;
        2: rb = ~ra;
        default: ;
      endcase
      run_req($sformatf("rnd%0d", n), e_alu_op'($urandom_range(0, 11)), ra, rb,
              int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
